// File: rtl/fq_wrr_sched_if.sv
// ---------------------------------------------------------------------------------------------
// fq_wrr_sched_if
//   Bundles the flow-FIFO side and the egress side of the WRR scheduler.
//   Parameters : NQ (number of queues), DW (data word width)
//   Signals    : fifo_empty / fifo_data / fifo_rdreq   per-queue show-ahead FIFO handshake
//                output_ready / output_data_valid / output_data   egress stream
//   Modports   : master - scheduler view, slave - FIFO/egress environment view
// ---------------------------------------------------------------------------------------------
interface fq_wrr_sched_if #(
    parameter int unsigned NQ = 8,
    parameter int unsigned DW = 64
);
    logic [NQ-1:0]         fifo_empty;
    logic [NQ-1:0][DW-1:0] fifo_data;
    logic [NQ-1:0]         fifo_rdreq;
    logic                  output_ready;
    logic                  output_data_valid;
    logic [DW-1:0]         output_data;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  output_ready,
        output fifo_rdreq,
        output output_data_valid,
        output output_data
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output output_ready,
        input  fifo_rdreq,
        input  output_data_valid,
        input  output_data
    );
endinterface

// File: rtl/fq_wrr_sched.sv
// ---------------------------------------------------------------------------------------------
// fq_wrr_sched
//   Weighted round-robin scheduler draining NQ show-ahead flow FIFOs onto one DW-bit stream.
//   Each queue gets a programmable quantum of words per turn; turns rotate in index order.
//   One IDLE scan cycle separates consecutive turns.
//
//   Ports:
//     clk, rst          clock, asynchronous active-low reset
//     cfg_we/qid/quantum  quantum write port (quantum 0 disables a queue)
//     bus               fq_wrr_sched_if.master: FIFO empty/data/rdreq, egress ready/valid/data
//     active_qid        queue currently (or last) served
//     busy              high while a turn is in progress
//
//   Optional build macro FQ_STATS_EN adds:
//     stat_qid          queue whose pop counter is read
//     stat_count        registered 32-bit pop count of queue stat_qid (1-cycle latency)
// ---------------------------------------------------------------------------------------------
module fq_wrr_sched #(
    parameter int unsigned NQ          = 8,
    parameter int unsigned DW          = 64,
    parameter int unsigned QW          = 8,
    parameter int unsigned DEF_QUANTUM = 4,
    localparam int unsigned QIDW       = (NQ > 1) ? $clog2(NQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic [QIDW-1:0] cfg_qid,
    input  logic [QW-1:0]   cfg_quantum,
    fq_wrr_sched_if.master  bus,
    output logic [QIDW-1:0] active_qid,
    output logic            busy
`ifdef FQ_STATS_EN
    ,
    input  logic [QIDW-1:0] stat_qid,
    output logic [31:0]     stat_count
`endif
);

    typedef enum logic [0:0] {StIdle, StServe} state_e;

    state_e          state_q, state_d;
    logic [QIDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [QIDW-1:0] act_q, act_d;
    logic [QW-1:0]   credit_q, credit_d;
    logic [QW-1:0]   quantum_q [NQ];
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;

    logic [NQ-1:0]   eligible;
    logic [NQ-1:0]   rdreq;
    logic [QIDW-1:0] scan_idx;
    logic [QIDW-1:0] pick;
    logic            found;
    logic            pop;

    always_comb begin
        eligible = '0;
        for (int q = 0; q < NQ; q++) begin
            eligible[q] = !bus.fifo_empty[q] && (quantum_q[q] != '0);
        end
    end

    // Priority scan starting at rr_ptr; index arithmetic wraps because NQ is a power of 2.
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        scan_idx = '0;
        for (int i = 0; i < NQ; i++) begin
            scan_idx = rr_ptr_q + QIDW'(i);
            if (!found && eligible[scan_idx]) begin
                found = 1'b1;
                pick  = scan_idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        act_d       = act_q;
        credit_d    = credit_q;
        rdreq       = '0;
        pop         = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    act_d    = pick;
                    credit_d = quantum_q[pick];
                    state_d  = StServe;
                end
            end
            StServe: begin
                pop = !bus.fifo_empty[act_q] && (!out_valid_q || bus.output_ready);
                if (pop) begin
                    rdreq[act_q] = 1'b1;
                    credit_d     = credit_q - QW'(1);
                    if (credit_q == QW'(1)) begin
                        state_d  = StIdle;
                        rr_ptr_d = act_q + QIDW'(1);
                    end
                end else if (bus.fifo_empty[act_q]) begin
                    // Queue ran dry: remaining credit is forfeited.
                    state_d  = StIdle;
                    rr_ptr_d = act_q + QIDW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // A pop overwrites the register even while the old word is being consumed.
        if (pop) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.fifo_data[act_q];
        end else if (bus.output_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            act_q       <= '0;
            credit_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            act_q       <= act_d;
            credit_q    <= credit_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Quantum writes to the active queue only matter at its next IDLE scan; credit is untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int q = 0; q < NQ; q++) begin
                quantum_q[q] <= QW'(DEF_QUANTUM);
            end
        end else if (cfg_we) begin
            quantum_q[cfg_qid] <= cfg_quantum;
        end
    end

    assign bus.fifo_rdreq        = rdreq;
    assign bus.output_data_valid = out_valid_q;
    assign bus.output_data       = out_data_q;
    assign active_qid            = act_q;
    assign busy                  = (state_q == StServe);

`ifdef FQ_STATS_EN
    logic [NQ-1:0][31:0] stat_cnt_q;
    logic [31:0]         stat_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_cnt_q   <= '0;
            stat_count_q <= '0;
        end else begin
            for (int q = 0; q < NQ; q++) begin
                if (rdreq[q]) begin
                    stat_cnt_q[q] <= stat_cnt_q[q] + 32'd1;
                end
            end
            stat_count_q <= stat_cnt_q[stat_qid];
        end
    end

    assign stat_count = stat_count_q;
`endif

endmodule

// File: doc/fq_wrr_sched.md
Name: fq_wrr_sched

Overview:
- Weighted round-robin scheduler that drains the 8 per-flow show-ahead FIFOs feeding the fair-queue datapath onto one 64-bit output stream.
- Each queue receives a programmable quantum of words per turn. Turns rotate strictly in queue-index order.
- Sits between the flow FIFOs and the egress stage; the egress stage back-pressures it with output_ready.

Parameters:
- NQ, 8, number of queues (power of 2)
- DW, 64, data word width
- QW, 8, quantum counter width
- DEF_QUANTUM, 4, reset quantum for every queue

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- cfg_we  in  1  write quantum
- cfg_qid  in  log2(NQ)  queue to configure
- cfg_quantum  in  QW  words per turn; 0 = queue disabled
- fifo_empty  in  [NQ] x 1  per-queue empty; show-ahead FIFOs, data valid whenever !empty
- fifo_data  in  [NQ] x DW  per-queue head word
- fifo_rdreq  out  [NQ] x 1  per-queue pop, one-hot or zero
- output_ready  in  1  egress accepts word
- output_data_valid  out  1  output register holds a word
- output_data  out  DW  output word
- active_qid  out  log2(NQ)  queue currently served
- busy  out  1  FSM in SERVE

Behaviour:
- Reset (rst low, async):
  - outputs: fifo_rdreq all 0, output_data_valid 0, output_data 0, active_qid 0, busy 0.
  - internal: rr_ptr 0, credit 0, all quanta = DEF_QUANTUM, FSM = IDLE.
- FSM:
  - IDLE: scan eligible queues (!fifo_empty && quantum != 0) starting at rr_ptr, wrapping at NQ-1 -> 0.
    - If one is found, next cycle: active_qid <= q, credit <= quantum[q], go to SERVE.
    - If none is eligible, stay in IDLE.
  - SERVE: pop condition = !fifo_empty[q] && (!output_data_valid || output_ready).
    - On pop: fifo_rdreq[q] = 1 (combinational), output_data <= fifo_data[q], output_data_valid <= 1, credit <= credit-1.
    - Exit to IDLE with rr_ptr <= q+1 (mod NQ) when a pop brings credit to 0, or when fifo_empty[q] with no pop this cycle. Unused credit is discarded.
- Output register: output_data_valid clears when output_ready && no new pop. Data is held stable while valid && !output_ready.
- Latency: word visible on output 1 cycle after its rdreq. There is one bubble cycle per queue switch (the IDLE scan).
- Throughput: 1 word/cycle within a turn while output_ready=1.
- fifo_rdreq is never asserted for an empty FIFO and never for more than one queue.
- Config:
  - cfg_we writes quantum[cfg_qid] at the clock edge.
  - A write to the active queue takes effect on its next turn; the current credit is unchanged.
  - A write of 0 removes the queue from the IDLE scan.
- Simultaneous cases:
  - Queue becomes non-empty during the IDLE scan cycle: sampled that cycle.
  - Pop on the same cycle output_ready consumes the old word: new word replaces it, valid stays 1.
- Reset mid-turn: the word in the output register is dropped, the FSM returns to IDLE, and rr_ptr returns to 0.

Optional Feature:
- FQ_STATS_EN defined: adds input stat_qid (log2(NQ)) and output stat_count (32) = words popped from queue stat_qid since reset.
  - One 32-bit counter per queue; increments on each fifo_rdreq[q] and wraps at 2^32.
  - stat_count is registered, 1-cycle read latency.
- Undefined: no counters, no stat ports.

Test Plan:
- Reset defaults: all queues hold 10 words, output_ready=1.
  - Output order is q0 x4, q1 x4, ... q7 x4, then repeats from q0.
  - Exactly 1 bubble cycle between turns.
- Weighted: quanta q0=1, q1=3, others 0; both queues hold 20 words.
  - Output pattern is q0, q1, q1, q1, repeating.
  - After 16 words: q0 count=4, q1 count=12.
- Short queue: q2 holds 2 words, quantum 4.
  - Turn ends after 2 pops and the unused credit is discarded.
  - rr_ptr becomes 3; the next turn goes to the next eligible queue.
- Back-pressure: hold output_ready=0 for 5 cycles mid-turn.
  - No rdreq during the stall; output_data stays stable; valid stays 1.
  - On release, words resume with no loss and no duplication.
- Async reset: assert rst=0 mid-SERVE, between clock edges.
  - Outputs go to reset values immediately.
  - After release, the first turn starts at the lowest eligible queue from index 0.
- FQ_STATS_EN: after the weighted test, stat_qid=1.
  - stat_count reads 12 one cycle later.
  - A counter preloaded to 0xFFFFFFFF reads 0 after the next pop.
